// File: rtl/l_tally.sv
// ============================================================================
// l_tally : counts L pulses per frame and hands totals off via valid/ready.
// Optional first_pos output under L_TALLY_FIRST_POS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module l_tally #(
    parameter int W  = 4,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          restart,
    input  logic          L,
    input  logic          frame_end,
    output logic [W-1:0]  count_out,
    output logic          count_sat,
    output logic          count_valid,
    input  logic          count_ready,
`ifdef L_TALLY_FIRST_POS_EN
    output logic [CW-1:0] first_pos,
`endif
    output logic          overrun
);

    localparam logic [W-1:0] c_cnt_max = '1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           sat_q, sat_d;
    logic [W-1:0]   out_q;
    logic           osat_q;
    logic           ovr_q, ovr_d;
    logic           w_load;
    logic [W-1:0]   w_snap_cnt;
    logic           w_snap_sat;

    // The snapshot includes this cycle's L so a pulse coincident with
    // frame_end is credited to the frame that is ending.  sat means the true
    // total exceeded what the counter can hold.
    always_comb begin
        w_snap_cnt = cnt_q;
        w_snap_sat = sat_q;
        if (L) begin
            if (cnt_q == c_cnt_max) begin
                w_snap_sat = 1'b1;
            end else begin
                w_snap_cnt = cnt_q + 1'b1;
            end
        end
        cnt_d = w_snap_cnt;
        sat_d = w_snap_sat;
        if (restart || frame_end) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        w_load  = 1'b0;
        if (restart) begin
            state_d = EMPTY;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (frame_end) begin
                        w_load  = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (frame_end) begin
                        if (count_ready) begin
                            w_load = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else if (count_ready) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            out_q   <= '0;
            osat_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
            if (w_load) begin
                out_q  <= w_snap_cnt;
                osat_q <= w_snap_sat;
            end
        end
    end

    assign count_out   = out_q;
    assign count_sat   = osat_q;
    assign count_valid = (state_q == FULL);
    assign overrun     = ovr_q;

`ifdef L_TALLY_FIRST_POS_EN
    localparam logic [CW-1:0] c_col_max = '1;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] fpos_q, fpos_d;
    logic          seen_q, seen_d;
    logic [CW-1:0] pos_out_q;
    logic [CW-1:0] w_snap_pos;

    always_comb begin
        col_d  = (col_q == c_col_max) ? col_q : col_q + 1'b1;
        fpos_d = fpos_q;
        seen_d = seen_q;
        if (L && !seen_q) begin
            fpos_d = col_q;
            seen_d = 1'b1;
        end
        // An empty frame reports the all-ones column index.
        w_snap_pos = seen_q ? fpos_q : (L ? col_q : c_col_max);
        if (restart || frame_end) begin
            col_d  = '0;
            fpos_d = '0;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            fpos_q    <= '0;
            seen_q    <= 1'b0;
            pos_out_q <= '0;
        end else begin
            col_q  <= col_d;
            fpos_q <= fpos_d;
            seen_q <= seen_d;
            if (w_load) begin
                pos_out_q <= w_snap_pos;
            end
        end
    end

    assign first_pos = pos_out_q;
`endif

endmodule

`default_nettype wire
